aes_bram_responder: RTL and testbench

AES_BRAM_RESPONDER -- requirements
Module: aes_bram_responder

---
 rtl/aes_bram_pkg.sv | 18 +
 rtl/aes_bram_responder_if.sv | 33 +++
 rtl/aes_bram_responder.sv | 97 +++++++++
 tb/tb_aes_bram_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_bram_pkg.sv
// Shared types and constants for the AES BRAM responder.
// FSM state encoding, byte-enable constant and default sizing.
package aes_bram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        DONE,
        RELEASE
    } state_t;

    localparam logic [3:0] WE_ALL = 4'hF;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_MEM_BYTES = 4096;

endpackage

// File: rtl/aes_bram_responder_if.sv
// Request/response bundle between the AES core and the BRAM responder.
// master = AES initiator, slave = responder.
interface aes_bram_responder_if;

    logic        aes_start_read;
    logic        aes_start_write;
    logic [31:0] aes_bram_addr;
    logic [31:0] aes_bram_write_data;
    logic [31:0] aes_bram_read_data;
    logic        bram_complete;
    logic        resp_err;

    modport master (
        output aes_start_read,
        output aes_start_write,
        output aes_bram_addr,
        output aes_bram_write_data,
        input  aes_bram_read_data,
        input  bram_complete,
        input  resp_err
    );

    modport slave (
        input  aes_start_read,
        input  aes_start_write,
        input  aes_bram_addr,
        input  aes_bram_write_data,
        output aes_bram_read_data,
        output bram_complete,
        output resp_err
    );

endinterface

// File: rtl/aes_bram_responder.sv
// Level-request to BRAM-port responder with one completion pulse per request.
// Optional macro AES_BRAM_ADDR_CHECK_EN rejects misaligned/out-of-range addresses.
module aes_bram_responder
    import aes_bram_pkg::*;
#(
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int MEM_BYTES    = DEF_MEM_BYTES
) (
    input  logic                 aes_clk,
    input  logic                 aes_rst_n,
    aes_bram_responder_if.slave  req,
    output logic                 bram_en,
    output logic [3:0]           bram_we,
    output logic [31:0]          bram_addr,
    output logic [31:0]          bram_din,
    input  logic [31:0]          bram_dout
);

    localparam int AW = $clog2(MEM_BYTES);

    state_t      state;
    state_t      state_n;
    logic [1:0]  cnt;
    logic        rd_last;
    logic        bad;
    logic [31:0] addr_word;

    // Word-aligned address wrapped into the BRAM
    assign addr_word = {{(32-AW){1'b0}}, req.aes_bram_addr[AW-1:2], 2'b00};
    assign rd_last   = (cnt == 2'(READ_LATENCY - 1));

`ifdef AES_BRAM_ADDR_CHECK_EN
    assign bad = (req.aes_bram_addr[1:0] != 2'b00) ||
                 (req.aes_bram_addr >= 32'(MEM_BYTES));
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req.aes_start_read)
                    state_n = bad ? DONE : RD_ISSUE;
                else if (req.aes_start_write)
                    state_n = bad ? DONE : WR_ISSUE;
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT:  if (rd_last) state_n = DONE;
            WR_ISSUE: state_n = DONE;
            DONE:     state_n = RELEASE;
            RELEASE: begin
                if (!req.aes_start_read && !req.aes_start_write)
                    state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state                  <= IDLE;
            cnt                    <= '0;
            bram_en                <= 1'b0;
            bram_we                <= '0;
            bram_addr              <= '0;
            bram_din               <= '0;
            req.aes_bram_read_data <= '0;
            req.bram_complete      <= 1'b0;
        end else begin
            state             <= state_n;
            bram_en           <= (state_n == RD_ISSUE) || (state_n == WR_ISSUE);
            bram_we           <= (state_n == WR_ISSUE) ? WE_ALL : 4'h0;
            req.bram_complete <= (state_n == DONE);
            cnt               <= (state == RD_WAIT) ? cnt + 2'd1 : 2'd0;
            if (state == IDLE && (state_n == RD_ISSUE || state_n == WR_ISSUE)) begin
                bram_addr <= addr_word;
                bram_din  <= req.aes_bram_write_data;
            end
            if (state == RD_WAIT && rd_last)
                req.aes_bram_read_data <= bram_dout;
        end
    end

`ifdef AES_BRAM_ADDR_CHECK_EN
    // Only a rejected request jumps straight from IDLE to DONE
    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n)
            req.resp_err <= 1'b0;
        else
            req.resp_err <= (state == IDLE) && (state_n == DONE);
    end
`else
    assign req.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_bram_responder.sv
// Self-checking bench for aes_bram_responder with behavioural BRAM and memory model.
// Covers read/write timing, held requests, priority, reset abort and address handling.
module tb_aes_bram_responder;
    import aes_bram_pkg::*;

    localparam int MEM = 4096;
    localparam int LAT = 1;
    localparam int AW  = $clog2(MEM);

    logic aes_clk   = 1'b0;
    logic aes_rst_n = 1'b1;
    always #5 aes_clk = ~aes_clk;

    aes_bram_responder_if bus ();
    aes_bram_responder_if bus3 ();

    logic        bram_en, bram_en3;
    logic [3:0]  bram_we, bram_we3;
    logic [31:0] bram_addr, bram_addr3;
    logic [31:0] bram_din, bram_din3;
    logic [31:0] bram_dout, bram_dout3;

    aes_bram_responder #(.READ_LATENCY(LAT), .MEM_BYTES(MEM)) dut (
        .aes_clk   (aes_clk),
        .aes_rst_n (aes_rst_n),
        .req       (bus.slave),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    aes_bram_responder #(.READ_LATENCY(3), .MEM_BYTES(MEM)) dut3 (
        .aes_clk   (aes_clk),
        .aes_rst_n (aes_rst_n),
        .req       (bus3.slave),
        .bram_en   (bram_en3),
        .bram_we   (bram_we3),
        .bram_addr (bram_addr3),
        .bram_din  (bram_din3),
        .bram_dout (bram_dout3)
    );

    // BRAM behaviour: LAT-stage read pipeline, full-word writes
    logic [31:0] mem [MEM/4];
    logic [31:0] pipe [LAT];
    assign bram_dout = pipe[LAT-1];
    always @(posedge aes_clk) begin
        pipe[0] <= mem[bram_addr[AW-1:2]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (bram_en && bram_we == WE_ALL) mem[bram_addr[AW-1:2]] <= bram_din;
    end

    logic [31:0] p3 [3];
    assign bram_dout3 = p3[2];
    always @(posedge aes_clk) begin
        p3[0] <= bram_addr3 ^ 32'hC0DE0000;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    logic [31:0] ref_mem [MEM/4];
    logic [31:0] exp_rd = '0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
`ifdef AES_BRAM_ADDR_CHECK_EN
        return (a % 4 != 0) || (a >= MEM);
`else
        return 1'b0;
`endif
    endfunction

    task automatic access(input string tag, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input int hold);
        int done_k = 0;
        int en_n = 0;
        int we_n = 0;
        int cmp_n = 0;
        logic err = 1'b0;
        logic [31:0] rdv = '0;
        logic [31:0] en_addr = '0;
        logic [31:0] en_din = '0;
        logic [3:0] en_we = '0;
        bit bad = is_bad(a);
        bit do_rd = rd;
        bit do_wr = wr && !rd;
        int idx = int'((a % MEM) / 4);
        int exp_k = bad ? 1 : (do_rd ? 2 + LAT : 2);
        int total = ((hold > exp_k) ? hold : exp_k) + 4;
        bus.aes_start_read = rd;
        bus.aes_start_write = wr;
        bus.aes_bram_addr = a;
        bus.aes_bram_write_data = d;
        for (int k = 1; k <= total; k++) begin
            @(negedge aes_clk);
            if (k == 1) begin
                bus.aes_bram_addr = $urandom;
                bus.aes_bram_write_data = $urandom;
            end
            if (bram_en) begin
                en_n++;
                en_addr = bram_addr;
                en_din = bram_din;
                en_we = bram_we;
            end
            if (bram_we != 4'h0) we_n++;
            if (bus.bram_complete) begin
                cmp_n++;
                if (done_k == 0) done_k = k;
                err = bus.resp_err;
                rdv = bus.aes_bram_read_data;
            end
            if (k == hold) begin
                bus.aes_start_read = 1'b0;
                bus.aes_start_write = 1'b0;
            end
        end
        if (!bad && do_wr) ref_mem[idx] = d;
        if (!bad && do_rd) exp_rd = ref_mem[idx];
        chk({tag, " latency"}, 32'(done_k), 32'(exp_k));
        chk({tag, " complete count"}, 32'(cmp_n), 32'd1);
        chk({tag, " en count"}, 32'(en_n), bad ? 32'd0 : 32'd1);
        chk({tag, " we count"}, 32'(we_n), (!bad && do_wr) ? 32'd1 : 32'd0);
        chk({tag, " resp_err"}, 32'(err), 32'(bad));
        chk({tag, " read_data"}, rdv, exp_rd);
        if (!bad) begin
            chk({tag, " bram_addr"}, en_addr, (a % MEM) & ~32'h3);
            chk({tag, " bram_we"}, 32'(en_we), do_wr ? 32'hF : 32'h0);
            if (do_wr) chk({tag, " bram_din"}, en_din, d);
        end
    endtask

    initial begin
        int k3;
        int c_main;
        int c3;
        logic [31:0] a;
        for (int i = 0; i < MEM/4; i++) begin
            mem[i] = 32'h5A5A0000 ^ (32'(i) * 32'h01010101);
            ref_mem[i] = 32'h5A5A0000 ^ (32'(i) * 32'h01010101);
        end
        mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        bus.aes_start_read = 0;
        bus.aes_start_write = 0;
        bus.aes_bram_addr = 0;
        bus.aes_bram_write_data = 0;
        bus3.aes_start_read = 0;
        bus3.aes_start_write = 0;
        bus3.aes_bram_addr = 0;
        bus3.aes_bram_write_data = 0;

        #2 aes_rst_n = 1'b0;
        #1;
        chk("reset en", 32'(bram_en), 32'd0);
        chk("reset we", 32'(bram_we), 32'd0);
        chk("reset addr", bram_addr, 32'd0);
        chk("reset din", bram_din, 32'd0);
        chk("reset rdata", bus.aes_bram_read_data, 32'd0);
        chk("reset complete", 32'(bus.bram_complete), 32'd0);
        chk("reset err", 32'(bus.resp_err), 32'd0);
        repeat (2) @(negedge aes_clk);
        aes_rst_n = 1'b1;
        @(negedge aes_clk);

        access("rd40", 1, 0, 32'h40, 32'h0, 3);
        chk("rd40 value", bus.aes_bram_read_data, 32'hDEADBEEF);
        access("wr80", 0, 1, 32'h80, 32'h12345678, 2);
        access("rd80", 1, 0, 32'h80, 32'h0, 3);
        chk("rd80 value", bus.aes_bram_read_data, 32'h12345678);
        access("held rd", 1, 0, 32'h44, 32'h0, 10);
        access("both", 1, 1, 32'h84, 32'hAAAA5555, 10);
        access("wr after both", 0, 1, 32'h84, 32'hAAAA5555, 10);
        access("rd84", 1, 0, 32'h84, 32'h0, 1);
        access("wr drop", 0, 1, 32'h88, 32'hCAFEF00D, 1);
        access("rd88", 1, 0, 32'h88, 32'h0, 4);
        access("addr 42", 1, 0, 32'h42, 32'h0, 4);
        access("addr 1000", 1, 0, 32'h1000, 32'h0, 4);
        access("wr 1004", 0, 1, 32'h1004, 32'h0BADF00D, 4);

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 2);
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF000);
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            access("rand", op != 1, op != 0, a, $urandom, $urandom_range(1, 8));
        end

        bus3.aes_start_read = 1'b1;
        bus3.aes_bram_addr = 32'h20C;
        k3 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge aes_clk);
            if (bus3.bram_complete && k3 == 0) begin
                k3 = k;
                chk("lat3 rdata", bus3.aes_bram_read_data, 32'h20C ^ 32'hC0DE0000);
            end
            if (k == 2) bus3.aes_start_read = 1'b0;
        end
        chk("lat3 latency", 32'(k3), 32'd5);

        bus.aes_start_read = 1'b1;
        bus.aes_bram_addr = 32'h40;
        bus3.aes_start_read = 1'b1;
        bus3.aes_bram_addr = 32'h30;
        repeat (2) @(negedge aes_clk);
        aes_rst_n = 1'b0;
        bus.aes_start_read = 1'b0;
        bus3.aes_start_read = 1'b0;
        #1;
        chk("abort en", 32'(bram_en3), 32'd0);
        chk("abort addr", bram_addr3, 32'd0);
        chk("abort rdata", bus3.aes_bram_read_data, 32'd0);
        chk("abort complete", 32'(bus3.bram_complete), 32'd0);
        chk("abort main addr", bram_addr, 32'd0);
        chk("abort main rdata", bus.aes_bram_read_data, 32'd0);
        exp_rd = '0;
        repeat (2) @(negedge aes_clk);
        aes_rst_n = 1'b1;
        c_main = 0;
        c3 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aes_clk);
            if (bus.bram_complete) c_main++;
            if (bus3.bram_complete) c3++;
        end
        chk("post-reset complete lat3", 32'(c3), 32'd0);
        chk("post-reset complete main", 32'(c_main), 32'd0);
        access("recover rd80", 1, 0, 32'h80, 32'h0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
